// File: rtl/compressor12_pkg.sv
// Shared constants and helpers for the Compressor12 datapath blocks.
package compressor12_pkg;

    localparam int WORD_W = 12;
    localparam int CNT_W  = 4;
    localparam int ACC_W  = WORD_W - 1;

    localparam logic [CNT_W-1:0] CNT_LAST = 4'd11;

    // Join the 11 held bits with the completing bit into a full word.
    // LSB-first streams hold bit i at acc[i], so the last bit is the MSB.
    // MSB-first streams hold word bit p at acc[p-1], so the last bit is the LSB.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [ACC_W-1:0] acc,
        input logic             last_bit,
        input logic             lsb_first
    );
        return lsb_first ? {last_bit, acc} : {acc, last_bit};
    endfunction

endpackage

// File: rtl/collector12_outreg.sv
// One-entry output holding register with a valid/ready handshake.
// The producer may load whenever can_load is high; a drain and a load on
// the same edge replace the word without dropping valid.
module collector12_outreg
    import compressor12_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic              ready,
    output logic              valid,
    output logic [WORD_W-1:0] q,
    output logic              can_load
);

    logic              full_q, full_d;
    logic [WORD_W-1:0] q_q, q_d;

    assign can_load = !full_q || ready;
    assign valid    = full_q;
    assign q        = q_q;

    // Next state: a load wins over a drain; otherwise a drain empties the entry.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        full_d = full_q;
        q_d    = q_q;
        if (load) begin
            q_d    = data;
            full_d = 1'b1;
        end else if (ready) begin
            full_d = 1'b0;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            // NOTE: the data register is reset too, because word_out is
            // visible at the port and must read 0 straight out of reset.
            q_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            full_q <= full_d;
            q_q    <= q_d;
        end
    end

endmodule

// File: rtl/collector12.sv
// Serial-to-parallel collector: packs one accepted bit per cycle into
// 12-bit words and hands them to a consumer through a holding register.
module collector12
    import compressor12_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    input  logic              sync,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  fill
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  wr_pos;
    logic [CNT_W-1:0]  acc_idx;
    logic              at_last;
    logic              accept;
    logic              complete;
    logic              can_load;
    logic [WORD_W-1:0] new_word;

    assign at_last  = (cnt_q == CNT_LAST);
    // Only the completing bit needs room in the holding register, so the
    // stall applies at cnt == 11 alone and word_ready is the only
    // combinational path to bit_ready.
    assign bit_ready = !(at_last && !can_load);
    assign accept    = bit_valid && bit_ready;
    // A sync on the completing bit restarts the word instead of finishing it.
    assign complete  = accept && at_last && !sync;
    assign new_word  = pack_word(acc_q, bit_in, LSB_FIRST);
    assign fill      = cnt_q;

    // Next state of the partial word: sync restarts it, accepted bits fill it.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        // After a sync the incoming bit is the first bit of a fresh word.
        wr_pos  = sync ? '0 : cnt_q;
        acc_idx = LSB_FIRST ? wr_pos : CNT_W'(ACC_W - 1) - wr_pos;
        if (sync) begin
            cnt_d = '0;
            acc_d = '0;
        end
        if (accept) begin
            if (complete) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                // Unwritten positions are always zero, so OR-ing places the bit.
                acc_d = acc_d | (ACC_W'(bit_in) << acc_idx);
                cnt_d = wr_pos + CNT_W'(1);
            end
        end
    end

    // Partial-word counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    collector12_outreg u_outreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (complete),
        .data     (new_word),
        .ready    (word_ready),
        .valid    (word_valid),
        .q        (word_out),
        .can_load (can_load)
    );

endmodule

// File: tb/tb_collector12.sv
// Self-checking bench for collector12: an LSB-first and an MSB-first
// instance share the same stimulus and are compared with a queue-based model.
module tb_collector12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in, bit_valid, sync, word_ready;
    logic        br_l, wv_l, br_m, wv_m;
    logic [11:0] wo_l, wo_m;
    logic [3:0]  fill_l, fill_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    collector12 #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(br_l), .sync(sync), .word_out(wo_l), .word_valid(wv_l),
        .word_ready(word_ready), .fill(fill_l)
    );

    collector12 #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(br_m), .sync(sync), .word_out(wo_m), .word_valid(wv_m),
        .word_ready(word_ready), .fill(fill_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: bits of the partial word in arrival order, plus the
    // held word as seen by each bit ordering.
    bit          mq[$];
    logic [11:0] m_lsb, m_msb;
    bit          m_full;
    bit          last_acc;

    task automatic model_reset();
        mq.delete();
        m_lsb  = '0;
        m_msb  = '0;
        m_full = 1'b0;
    endtask

    function automatic bit model_ready(input bit wr);
        return !(mq.size() == 11 && m_full && !wr);
    endfunction

    task automatic check_outputs(input bit wr);
        check("fill_lsb",  32'(fill_l), 32'(mq.size()));
        check("fill_msb",  32'(fill_m), 32'(mq.size()));
        check("valid_lsb", 32'(wv_l),   32'(m_full));
        check("valid_msb", 32'(wv_m),   32'(m_full));
        check("word_lsb",  32'(wo_l),   32'(m_lsb));
        check("word_msb",  32'(wo_m),   32'(m_msb));
        check("ready_lsb", 32'(br_l),   32'(model_ready(wr)));
        check("ready_msb", 32'(br_m),   32'(model_ready(wr)));
    endtask

    // One clock: drive, compare at the falling edge, advance the model,
    // then return 1 time unit after the rising edge.
    task automatic cycle(input bit bv, input bit bi, input bit sy, input bit wr);
        bit acc, drain, done;
        bit_valid  = bv;
        bit_in     = bi;
        sync       = sy;
        word_ready = wr;
        @(negedge clk);
        check_outputs(wr);
        acc   = bv && model_ready(wr);
        drain = m_full && wr;
        done  = 1'b0;
        if (sy) begin
            mq.delete();
            if (acc) mq.push_back(bi);
        end else if (acc) begin
            mq.push_back(bi);
            if (mq.size() == 12) begin
                for (int i = 0; i < 12; i++) begin
                    m_lsb[i]      = mq[i];
                    m_msb[11 - i] = mq[i];
                end
                m_full = 1'b1;
                done   = 1'b1;
                mq.delete();
            end
        end
        if (!done && drain) m_full = 1'b0;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    bit          s1 [12] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
    logic [11:0] w123    = 12'h123;

    initial begin
        int idx;
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        sync       = 1'b0;
        word_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        check("rst_word",  32'(wo_l),   32'h000);
        check("rst_valid", 32'(wv_l),   32'h0);
        check("rst_fill",  32'(fill_l), 32'h0);
        check("rst_ready", 32'(br_l),   32'h1);

        // Directed stream with the consumer always ready.
        for (int i = 0; i < 12; i++) cycle(1'b1, s1[i], 1'b0, 1'b1);
        check("t1_word_lsb", 32'(wo_l), 32'hA5C);
        check("t1_word_msb", 32'(wo_m), 32'h3A5);
        check("t1_valid",    32'(wv_l), 32'h1);
        check("t1_fill",     32'(fill_l), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_valid_one_cycle", 32'(wv_l), 32'h0);

        // Stalled consumer: 0xFFF then 0x001, no bit may be lost.
        idx = 0;
        for (int c = 0; c < 40 && idx < 23; c++) begin
            cycle(1'b1, (idx <= 12), 1'b0, 1'b0);
            if (last_acc) idx++;
        end
        check("t3_bits_accepted", 32'(idx), 32'd23);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_stall_ready", 32'(br_l),   32'h0);
        check("t3_stall_fill",  32'(fill_l), 32'd11);
        check("t3_stall_word",  32'(wo_l),   32'hFFF);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t3_next_lsb",  32'(wo_l), 32'h001);
        check("t3_next_msb",  32'(wo_m), 32'h800);
        check("t3_next_valid", 32'(wv_l), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_drained", 32'(wv_l), 32'h0);

        // Partial word discarded by sync; the sync bit starts the new word.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_fill_after_sync", 32'(fill_l), 32'h1);
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_word_lsb", 32'(wo_l), 32'h001);
        check("t4_word_msb", 32'(wo_m), 32'h800);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Sync leaves a held word untouched.
        for (int i = 0; i < 12; i++) cycle(1'b1, w123[i], 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("t5_word_lsb", 32'(wo_l), 32'h123);
        check("t5_word_msb", 32'(wo_m), 32'hC48);
        check("t5_valid",    32'(wv_l), 32'h1);

        // Asynchronous reset mid-word with a word held.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("t6_fill_pre", 32'(fill_l), 32'd7);
        check("t6_valid_pre", 32'(wv_l), 32'h1);
        bit_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_async", 32'(wv_l),   32'h0);
        check("t6_fill_async",  32'(fill_l), 32'h0);
        check("t6_word_async",  32'(wo_l),   32'h000);
        check("t6_word_msb_async", 32'(wo_m), 32'h000);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
